// File: rtl/trisc_disp_pkg.sv
// Shared constants for the TRISC debug display blocks.
package trisc_disp_pkg;

    // Width of one hex digit.
    localparam int NIBBLE_W = 4;

    // Largest supported display, in digits.
    localparam int MAX_DIGITS = 8;

    // All digit enables off (the digit selects are active-low).
    localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

    // Clocks per digit slot: about 1 kHz per digit from the 50 MHz board clock.
    localparam int PRESCALE_BOARD = 50000;

    // Short digit slot so a simulation can cover several frames quickly.
    localparam int PRESCALE_SIM = 4;

endpackage

// File: rtl/trisc_hex_scan_if.sv
// Value/load inputs and the scanned digit outputs of the hex display scanner.
interface trisc_hex_scan_if
    import trisc_disp_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                         load;
    logic [NIBBLE_W*DIGITS-1:0]   value;
    logic                         blank_en;
    logic [NIBBLE_W-1:0]          nibble;
    logic [DIGITS-1:0]            digit_sel;
    logic                         digit_blank;
    logic                         frame_pulse;

    // Side that supplies the value to show and consumes the digit drive.
    modport master (
        output load,
        output value,
        output blank_en,
        input  nibble,
        input  digit_sel,
        input  digit_blank,
        input  frame_pulse
    );

    // The scanner itself.
    modport slave (
        input  load,
        input  value,
        input  blank_en,
        output nibble,
        output digit_sel,
        output digit_blank,
        output frame_pulse
    );

endinterface

// File: rtl/trisc_scan_prescaler.sv
// Digit-slot prescaler: counts PRESCALE clocks and strobes tick on the last one.
module trisc_scan_prescaler
    import trisc_disp_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_BOARD
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == PW'(PRESCALE - 1));

    // Free-running 0..PRESCALE-1 counter, restarted by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/trisc_hex_scan.sv
// Time-multiplexed hex display scanner: walks a double-buffered value one
// nibble per digit slot, with active-low digit select and leading-zero blanking.
module trisc_hex_scan
    import trisc_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = PRESCALE_BOARD
) (
    input  logic              clk,
    input  logic              rst,
    trisc_hex_scan_if.slave   bus
);

    localparam int IW = $clog2(DIGITS);
    localparam int VW = NIBBLE_W * DIGITS;

    logic                tick;
    logic                wrap;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [VW-1:0]       active;
    logic [VW-1:0]       active_next;
    logic [VW-1:0]       pending;
    logic                pend_v;
    logic [NIBBLE_W-1:0] nib_next;
    logic [DIGITS-1:0]   sel_next;
    logic [DIGITS-1:0]   zero_from;
    logic                blank_next;
    logic                all_zero;

    trisc_scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // Next digit index: advance per slot, back to digit 0 at the frame boundary.
    always_comb begin
        idx_next = idx;
        if (wrap) begin
            idx_next = '0;
        end else if (tick) begin
            idx_next = idx + 1'b1;
        end
    end

    // Next displayed value: only swapped at a frame boundary; a load on the
    // boundary itself bypasses the pending buffer and wins over older data.
    always_comb begin
        active_next = active;
        if (wrap) begin
            if (bus.load) begin
                active_next = bus.value;
            end else if (pend_v) begin
                active_next = pending;
            end
        end
    end

    // Digit drive for the next state, so the registered outputs line up with
    // the index and value being entered on the same edge.
    always_comb begin
        nib_next   = '0;
        sel_next   = DIGIT_OFF[DIGITS-1:0];
        zero_from  = '0;
        blank_next = 1'b0;
        all_zero   = 1'b1;
        // zero_from[i]: digits i..DIGITS-1 of the next value are all zero.
        for (int unsigned k = 0; k < DIGITS; k++) begin
            all_zero = all_zero
                && (active_next[NIBBLE_W*(DIGITS-1-k) +: NIBBLE_W] == '0);
            zero_from[DIGITS-1-k] = all_zero;
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                nib_next    = active_next[NIBBLE_W*i +: NIBBLE_W];
                sel_next[i] = 1'b0;
                // Digit 0 always shows, so a zero value reads "0".
                blank_next  = bus.blank_en && (i != 0) && zero_from[i];
            end
        end
    end

    // Scan state, load buffering and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            active          <= '0;
            pending         <= '0;
            pend_v          <= 1'b0;
            bus.nibble      <= '0;
            bus.digit_sel   <= {DIGIT_OFF[DIGITS-1:1], 1'b0};
            bus.digit_blank <= 1'b0;
            bus.frame_pulse <= 1'b0;
        end else begin
            idx    <= idx_next;
            active <= active_next;
            if (bus.load && !wrap) begin
                pending <= bus.value;
                pend_v  <= 1'b1;
            end else if (wrap) begin
                pend_v  <= 1'b0;
            end
            bus.nibble      <= nib_next;
            bus.digit_sel   <= sel_next;
            bus.digit_blank <= blank_next;
            bus.frame_pulse <= wrap;
        end
    end

endmodule

// File: tb/tb_trisc_hex_scan.sv
// Directed self-checking bench for trisc_hex_scan with DIGITS=4, PRESCALE=4.
module tb_trisc_hex_scan;
    import trisc_disp_pkg::*;

    localparam int DIG = 4;
    localparam int PS  = PRESCALE_SIM;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    trisc_hex_scan_if #(.DIGITS(DIG)) bus ();

    trisc_hex_scan #(
        .DIGITS   (DIG),
        .PRESCALE (PS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] sel, input logic [3:0] nib,
                              input logic blank, input logic fp);
        check({tag, ".sel"},   32'(bus.digit_sel),   32'(sel));
        check({tag, ".nib"},   32'(bus.nibble),      32'(nib));
        check({tag, ".blank"}, 32'(bus.digit_blank), 32'(blank));
        check({tag, ".fp"},    32'(bus.frame_pulse), 32'(fp));
    endtask

    // Check count consecutive cycles, starting at cycle 'first' within a frame.
    task automatic check_cycles(input string tag, input int first, input int count,
                                input logic [15:0] val, input logic [3:0] blanks,
                                input logic fp0);
        for (int i = 0; i < count; i++) begin
            int         off;
            int         d;
            logic [3:0] sel;
            logic       fp;
            off = first + i;
            d   = off / PS;
            sel = ~(4'b0001 << d);
            fp  = (off == 0) ? fp0 : 1'b0;
            expect_out($sformatf("%s[%0d]", tag, off), sel, val[4*d +: 4], blanks[d], fp);
            if (i != count - 1) step();
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.blank_en = 1'b0;

        // Reset state, then digit 0 held 4 cycles before moving to digit 1.
        step();
        step();
        expect_out("reset", 4'b1110, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("hold%0d", i), 4'b1110, 4'h0, 1'b0, 1'b0);
        end
        step();
        expect_out("digit1", 4'b1101, 4'h0, 1'b0, 1'b0);
        repeat (11) step();

        // Load A3C5 on the frame boundary: shown immediately, full frame.
        bus.load  = 1'b1;
        bus.value = 16'hA3C5;
        step();
        bus.load = 1'b0;
        check_cycles("a3c5", 0, 16, 16'hA3C5, 4'b0000, 1'b1);

        // FFFF on the boundary, then 1234 mid-frame: rest of frame stays F.
        bus.load  = 1'b1;
        bus.value = 16'hFFFF;
        step();
        bus.load = 1'b0;
        check_cycles("ffff", 0, 6, 16'hFFFF, 4'b0000, 1'b1);
        bus.load  = 1'b1;
        bus.value = 16'h1234;
        step();
        bus.load = 1'b0;
        check_cycles("ffff", 6, 10, 16'hFFFF, 4'b0000, 1'b1);
        step();

        // Next frame shows 1234; 5555 queued mid-frame.
        check_cycles("1234", 0, 3, 16'h1234, 4'b0000, 1'b1);
        bus.load  = 1'b1;
        bus.value = 16'h5555;
        step();
        bus.load = 1'b0;
        check_cycles("1234", 3, 13, 16'h1234, 4'b0000, 1'b1);

        // 9876 coincides with the wrap: taken directly, 5555 never appears.
        bus.load  = 1'b1;
        bus.value = 16'h9876;
        step();
        bus.load = 1'b0;
        check_cycles("9876a", 0, 16, 16'h9876, 4'b0000, 1'b1);
        step();
        check_cycles("9876b", 0, 16, 16'h9876, 4'b0000, 1'b1);

        // Leading-zero blanking.
        bus.blank_en = 1'b1;
        bus.load     = 1'b1;
        bus.value    = 16'h0040;
        step();
        bus.load = 1'b0;
        check_cycles("blank0040", 0, 16, 16'h0040, 4'b1100, 1'b1);
        bus.load  = 1'b1;
        bus.value = 16'h0000;
        step();
        bus.load = 1'b0;
        check_cycles("blank0000", 0, 16, 16'h0000, 4'b1110, 1'b1);
        bus.blank_en = 1'b0;
        step();
        check_cycles("noblank", 0, 16, 16'h0000, 4'b0000, 1'b1);

        // Reset mid-frame with a load pending and a load during reset.
        step();
        step();
        bus.load  = 1'b1;
        bus.value = 16'h7777;
        step();
        bus.load = 1'b0;
        repeat (3) step();
        rst       = 1'b1;
        bus.load  = 1'b1;
        bus.value = 16'hBBBB;
        step();
        expect_out("rst_mid", 4'b1110, 4'h0, 1'b0, 1'b0);
        rst      = 1'b0;
        bus.load = 1'b0;
        check_cycles("post_rst", 0, 16, 16'h0000, 4'b0000, 1'b0);
        step();
        check_cycles("after_wrap", 0, 16, 16'h0000, 4'b0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trisc_hex_scan.md
# trisc_hex_scan

Time-multiplexed hex display scanner for the TRISC debug display. It captures a multi-digit hex value, such as the PC or a register, and walks it one nibble per refresh tick. Each step drives one digit's nibble to the downstream hex-to-seven-segment decoder, together with a one-hot active-low digit select and a blank flag. Value updates are double-buffered so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, default 4: number of display digits, range 2..8
- `PRESCALE`, default 50000: clocks per digit slot, minimum 2
- `clk`  in  1: system clock; all state updates on the rising edge
- `rst`  in  1: synchronous, active-high reset
- `load`  in  1: capture `value` this cycle
- `value`  in  4*DIGITS: hex value; nibble 0 is the least significant digit
- `blank_en`  in  1: enable leading-zero suppression (sampled live)
- `nibble`  out  4: nibble for the current digit, to the decoder input
- `digit_sel`  out  DIGITS: one-hot, active-low digit enable
- `digit_blank`  out  1: 1 = force segments off for the current digit
- `frame_pulse`  out  1: one-cycle pulse when scanning wraps back to digit 0

## Operation
- Internal state:
  - prescale counter `pcnt`, range 0..PRESCALE-1
  - digit index `idx`, range 0..DIGITS-1
  - `active` register: the value being displayed
  - `pending` register plus `pend_v` valid flag
- `tick` = (`pcnt` == PRESCALE-1). On `tick`, `pcnt` returns to 0; otherwise it increments.
- On `tick`, `idx` advances by 1. From DIGITS-1 it wraps to 0; this is the frame boundary, `wrap`.
- Load buffering:
  - `load` with no `wrap` in the same cycle: `pending` <= `value`, `pend_v` <= 1.
  - `wrap` with `pend_v` = 1 and no `load`: `active` <= `pending`, `pend_v` <= 0.
  - `load` and `wrap` in the same cycle: `active` <= `value` directly, `pend_v` <= 0. An older pending value is discarded.
  - Back-to-back loads within one frame: the last one wins.
- Outputs are registered and reflect the new `idx` and `active`:
  - `nibble` = `active[4*idx +: 4]`
  - `digit_sel` = ~(1 << idx)
- Blanking: `digit_blank` = 1 when `blank_en` is set, `idx` > 0, and every nibble from `idx` to DIGITS-1 of `active` is zero. Digit 0 is never blanked, so a value of 0 displays as "0".
- `frame_pulse` is high for the cycle after `wrap`, coincident with digit 0 first being shown.

## Timing
- Reset values:
  - `pcnt` = 0, `idx` = 0, `active` = 0, `pending` = 0, `pend_v` = 0
  - `nibble` = 0, `digit_sel` = ~1 (digit 0 lit), `digit_blank` = 0, `frame_pulse` = 0
- Each digit is held for exactly PRESCALE cycles; a frame is DIGITS*PRESCALE cycles.
- Output latency: outputs change one cycle after the `tick` edge, i.e. on the registered edge.
- Load-to-display latency is at most one frame plus one cycle. It is exactly one cycle when `load` coincides with `wrap`.
- Reset asserted mid-frame: everything returns to reset values on the next edge and a pending load is lost. Scanning restarts at digit 0 with a full PRESCALE hold.
- `load` during `rst` is ignored.

## Structure
- Shared package `trisc_disp_pkg`:
  - `DIGIT_OFF` constant (all ones)
  - `NIBBLE_W` = 4
  - default `PRESCALE` constants for the 50 MHz board clock and for simulation
- Natural sub-module: `trisc_scan_prescaler`, holding `pcnt` and producing the `tick` strobe.
- The top level holds the index, buffering and blanking logic.
- The downstream decoder is instantiated by the integrating top, not inside this block.

## Test plan
- Reset with DIGITS=4, PRESCALE=4:
  - `digit_sel`=4'b1110, `nibble`=0, `digit_blank`=0, `frame_pulse`=0.
  - `digit_sel` holds for 4 cycles, then goes to 4'b1101.
- Load 16'hA3C5 at frame start, then wait one frame:
  - `nibble` sequence is 5, C, 3, A, each held 4 cycles, with the matching `digit_sel`.
  - `frame_pulse` appears once per 16 cycles.
- Load 16'h1234 mid-frame while 16'hFFFF is displayed:
  - remaining digits of the frame still show F.
  - the next frame shows 4, 3, 2, 1.
- Load coinciding with `wrap`, with a different older value still pending:
  - `active` takes the coincident value directly.
  - the older pending value is never displayed.
- Load 16'h0040 with `blank_en`=1:
  - `digit_blank` = 0, 0, 1, 1 for digits 0..3.
  - with value 0, only digit 3..1 are blanked and digit 0 shows 0.
  - with `blank_en`=0, nothing is blanked.
- Assert `rst` for 1 cycle mid-frame with a load pending:
  - all outputs return to reset values.
  - the pending value is lost; `active` stays 0 after the next `wrap`.
